// File: rtl/m14k_mbist_marchc_if.sv
// m14k_mbist_marchc_if
//   Bundle of the BIST control/result signals and the single-port SRAM
//   test port driven by one March C- sequencer.
//   master : sequencer side (drives array port and results, takes start/rdata)
//   slave  : controller + array side (drives start/rdata, observes the rest)
interface m14k_mbist_marchc_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          bist_start;
  logic          bist_busy;
  logic          bist_done;
  logic          bist_fail;
  logic [AW-1:0] bist_fail_addr;
  logic [2:0]    bist_fail_elem;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  bist_start, mem_rdata,
    output bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_elem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output bist_start, mem_rdata,
    input  bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_elem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/m14k_mbist_marchc.sv
// m14k_mbist_marchc
//   March C- sequencer for one single-port synchronous SRAM.
//   Elements: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1)
//             E4 down(r1,w0) E5 up(r0); "0" = BG, "1" = ~BG.
//   One array op per cycle while running; read data returns one cycle
//   after issue and is compared against the expectation carried with it.
// Ports
//   gclk    core clock
//   greset  synchronous reset, active-high
//   bus     master modport: bist_start/busy/done/fail/fail_addr/fail_elem
//           and the array port mem_en/we/addr/wdata/rdata
module m14k_mbist_marchc #(
  parameter int          AW = 8,
  parameter int          DW = 32,
  parameter logic [DW-1:0] BG = '0
) (
  input logic                  gclk,
  input logic                  greset,
  m14k_mbist_marchc_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ph_q, ph_d;        // 1: write slot of an r,w element

  // read compare pipeline (one stage: issue -> data back)
  logic          rd_vld_q;
  logic [DW-1:0] rd_exp_q;
  logic [AW-1:0] rd_addr_q;
  logic [2:0]    rd_elem_q;

  logic          fail_q;
  logic [AW-1:0] fail_addr_q;
  logic [2:0]    fail_elem_q;

  logic          run, down, single, op_we, last_addr, start_ok, miscmp;
  logic [DW-1:0] rd_val, wr_val;

  assign run       = (state_q == S_RUN);
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign single    = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign op_we     = (elem_q == 3'd0) || ph_q;
  assign last_addr = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign rd_val    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
  assign wr_val    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BG : BG;
  assign start_ok  = bus.bist_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign miscmp    = rd_vld_q && (bus.mem_rdata != rd_exp_q);

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.bist_start) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          ph_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (!single && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = S_FLUSH;
              addr_d  = '0;
            end else begin
              elem_d = elem_q + 3'd1;
              // E3 and E4 walk downward; everything else walks up
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (greset) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      addr_q    <= addr_d;
      ph_q      <= ph_d;
      rd_vld_q  <= run && !op_we;
      rd_exp_q  <= rd_val;
      rd_addr_q <= addr_q;
      rd_elem_q <= elem_q;
      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
      end else if (miscmp) begin
        fail_q <= 1'b1;
        // only the first miscompare of a run is recorded
        if (!fail_q) begin
          fail_addr_q <= rd_addr_q;
          fail_elem_q <= rd_elem_q;
        end
      end
    end
  end

  // greset also drops the array enable in the cycle it is asserted so a
  // mid-run reset never lets another op reach the array
  assign bus.mem_en         = run && !greset;
  assign bus.mem_we         = run && op_we && !greset;
  assign bus.mem_addr       = run ? addr_q : '0;
  assign bus.mem_wdata      = (run && op_we) ? wr_val : '0;
  assign bus.bist_busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign bus.bist_done      = (state_q == S_DONE);
  assign bus.bist_fail      = fail_q;
  assign bus.bist_fail_addr = fail_addr_q;
  assign bus.bist_fail_elem = fail_elem_q;

endmodule
